// File: rtl/asynchronous_fifo_write_controller_pkg.sv
// rtl/asynchronous_fifo_write_controller_pkg.sv - shared Gray/binary pointer helpers for both FIFO controllers
package asynchronous_fifo_package;

    // Widest pointer the helpers handle; narrower pointers are zero-extended on the way in
    // and truncated on the way out, which leaves both conversions exact.
    localparam int MAX_POINTER_WIDTH = 32;
    localparam int DEFAULT_DATA_DEPTH = 4096;

    typedef logic [MAX_POINTER_WIDTH-1:0] pointer_word_t;

    function automatic int pointer_width(input int depth);
        return $clog2(depth);
    endfunction

    localparam int DEFAULT_POINTER_WIDTH = pointer_width(DEFAULT_DATA_DEPTH);

    function automatic pointer_word_t binary_to_gray(input pointer_word_t binary);
        return binary ^ (binary >> 1);
    endfunction

    // Bit i of the binary value is the XOR of all Gray bits at or above i.
    function automatic pointer_word_t gray_to_binary(input pointer_word_t gray);
        pointer_word_t binary;
        binary[MAX_POINTER_WIDTH-1] = gray[MAX_POINTER_WIDTH-1];
        for (int i = MAX_POINTER_WIDTH - 2; i >= 0; i--) begin
            binary[i] = binary[i+1] ^ gray[i];
        end
        return binary;
    endfunction

endpackage

// File: rtl/asynchronous_fifo_write_controller_synchronizer.sv
// rtl/asynchronous_fifo_write_controller_synchronizer.sv - two-flop vector synchronizer for Gray pointers
module asynchronous_fifo_pointer_synchronizer #(
    parameter int WIDTH = 12
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out
);

    logic [WIDTH-1:0] sync_0;
    logic [WIDTH-1:0] sync_1;

    // Two back-to-back capture stages; only one Gray bit changes per step, so the vector is safe.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_0 <= '0;
            sync_1 <= '0;
        end else begin
            sync_0 <= data_in;
            sync_1 <= sync_0;
        end
    end

    assign data_out = sync_1;

endmodule

// File: rtl/asynchronous_fifo_write_controller.sv
// rtl/asynchronous_fifo_write_controller.sv - write-domain FIFO controller; ASYNCHRONOUS_FIFO_WRITE_OVERFLOW_COUNT_EN adds overflow_count
module asynchronous_fifo_write_controller
    import asynchronous_fifo_package::*;
#(
    parameter int DATA_WIDTH            = 16,
    parameter int DATA_DEPTH            = 4096,
    parameter int ALMOST_FULL_THRESHOLD = DATA_DEPTH - 4
) (
    input  logic                                 clock,
    input  logic                                 reset_n,
    input  logic                                 write_enable,
    input  logic [DATA_WIDTH-1:0]                write_data,
    input  logic [pointer_width(DATA_DEPTH)-1:0] read_pointer_gray,
    output logic                                 memory_write_enable,
    output logic [pointer_width(DATA_DEPTH)-1:0] memory_write_address,
    output logic [DATA_WIDTH-1:0]                memory_write_data,
    output logic [pointer_width(DATA_DEPTH)-1:0] write_pointer_gray,
    output logic                                 full,
    output logic                                 almost_full,
    output logic [pointer_width(DATA_DEPTH)-1:0] write_level,
    output logic                                 overflow
`ifdef ASYNCHRONOUS_FIFO_WRITE_OVERFLOW_COUNT_EN
    ,
    output logic [15:0]                          overflow_count
`endif
);

    localparam int POINTER_WIDTH = pointer_width(DATA_DEPTH);
    localparam logic [POINTER_WIDTH-1:0] POINTER_ONE  = POINTER_WIDTH'(1);
    localparam logic [POINTER_WIDTH-1:0] AF_THRESHOLD = POINTER_WIDTH'(ALMOST_FULL_THRESHOLD);

    logic [POINTER_WIDTH-1:0] write_pointer;
    logic [POINTER_WIDTH-1:0] read_pointer_sync_gray;
    logic [POINTER_WIDTH-1:0] read_pointer_sync;
    logic [POINTER_WIDTH-1:0] next_ptr;
    logic [POINTER_WIDTH-1:0] ptr_after_next;
    logic [POINTER_WIDTH-1:0] level_next;
    logic                     accept;

    asynchronous_fifo_pointer_synchronizer #(
        .WIDTH (POINTER_WIDTH)
    ) u_read_pointer_synchronizer (
        .clock    (clock),
        .reset_n  (reset_n),
        .data_in  (read_pointer_gray),
        .data_out (read_pointer_sync_gray)
    );

    // Reset gating keeps the memory strobe low while reset is held, even with write_enable high.
    assign accept               = write_enable && !full && reset_n;
    assign memory_write_enable  = accept;
    assign memory_write_address = write_pointer;
    assign memory_write_data    = write_data;

    assign read_pointer_sync = POINTER_WIDTH'(gray_to_binary(pointer_word_t'(read_pointer_sync_gray)));

    // Power-of-two depth, so the natural pointer wrap is the DATA_DEPTH-1 -> 0 wrap.
    assign next_ptr       = accept ? write_pointer + POINTER_ONE : write_pointer;
    assign ptr_after_next = next_ptr + POINTER_ONE;
    assign level_next     = next_ptr - read_pointer_sync;

    // Pointer, published Gray pointer and flags all come from flops; one slot stays empty to tell full from empty.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            write_pointer      <= '0;
            write_pointer_gray <= '0;
            write_level        <= '0;
            full               <= 1'b0;
            almost_full        <= 1'b0;
            overflow           <= 1'b0;
        end else begin
            write_pointer      <= next_ptr;
            write_pointer_gray <= POINTER_WIDTH'(binary_to_gray(pointer_word_t'(next_ptr)));
            write_level        <= level_next;
            full               <= (ptr_after_next == read_pointer_sync);
            almost_full        <= (level_next >= AF_THRESHOLD);
            overflow           <= write_enable && full;
        end
    end

`ifdef ASYNCHRONOUS_FIFO_WRITE_OVERFLOW_COUNT_EN
    // Saturating count of dropped writes, advanced on the same edge that raises the overflow pulse.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            overflow_count <= 16'h0000;
        end else if (write_enable && full && (overflow_count != 16'hFFFF)) begin
            overflow_count <= overflow_count + 16'h0001;
        end
    end
`endif

endmodule
